// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder datapath and controller.
//
// Captures a, b and cin on an accepted start. Each following cycle it feeds one bit
// pair (LSB first) and the running carry through a single full-adder cell. The sum is
// assembled in a right-shifting register. sum/cout are registered and change only
// on entry to the done cycle, and are held until the next accepted start.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  request, sampled only while busy=0 (idle or done cycle)
//   a, b   operands (WIDTH bits), cin carry-in; captured on accepted start
//   sub    (SERIAL_ADD_SUB_EN only) 1: compute a - b, cin ignored
//   busy   high while the serial addition runs
//   done   one-cycle pulse, sum/cout valid
//   sum    result, cout final carry (1 = no borrow when subtracting)
//
// Optional feature: define SERIAL_ADD_SUB_EN to add the sub input.

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_sr_q, sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q, busy_q, done_q, cout_q;

  logic [WIDTH-1:0] b_cap;
  logic             cin_cap;
  logic [WIDTH-1:0] sum_sr_d;
  logic             fa_sum, fa_cout, last_bit;

  // Subtraction is a + ~b + 1: invert B on capture and seed the carry with 1.
  always_comb begin
    b_cap   = b;
    cin_cap = cin;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      b_cap   = ~b;
      cin_cap = 1'b1;
    end
`endif
  end

  // Single full-adder cell shared across all bit positions.
  assign fa_sum  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign fa_cout = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));

  // New bit enters at the MSB; after WIDTH shifts bit 0 holds the first sum bit.
  assign sum_sr_d = WIDTH'({fa_sum, sum_sr_q} >> 1);
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            a_sr_q   <= a;
            b_sr_q   <= b_cap;
            carry_q  <= cin_cap;
            sum_sr_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          carry_q  <= fa_cout;
          sum_sr_q <= sum_sr_d;
          cnt_q    <= cnt_q + 1'b1;
          if (last_bit) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= sum_sr_d;
            cout_q  <= fa_cout;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         cin_i = 1'b0;
  logic         sub_i = 1'b0;
  logic         busy_o, done_o, cout_o;
  logic [W-1:0] sum_o;

  int n_checks = 0;
  int n_errors = 0;

  // Last completed result (what sum/cout must hold) and in-flight expectation.
  logic [W-1:0] model_sum = '0;
  logic         model_cout = 1'b0;
  logic [W-1:0] pend_sum;
  logic         pend_cout;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_i),
    .a     (a_i),
    .b     (b_i),
    .cin   (cin_i),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub_i),
`endif
    .busy  (busy_o),
    .done  (done_o),
    .sum   (sum_o),
    .cout  (cout_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an operation and let the next edge accept it; operands are then scrambled.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                          input logic sv);
    logic [W:0] tot;
    if (sv) tot = {1'b0, av} - {1'b0, bv} + (W+1)'(1 << W);
    else    tot = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    pend_sum  = tot[W-1:0];
    pend_cout = tot[W];
    a_i = av; b_i = bv; cin_i = cv; sub_i = sv; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom);
    check_eq("accept_busy", 32'(busy_o), 32'd1);
  endtask

  // Wait for done; optionally pulse start (with junk operands) while busy.
  task automatic wait_done(input int inject);
    int  k = 0;
    bit  held_ok = 1'b1;
    while (k < 3 * W) begin
      @(posedge clk); #1;
      k++;
      start_i = (k == inject);
      if (k == inject) a_i = 8'h01;
      if (done_o) break;
      if (busy_o !== 1'b1 || sum_o !== model_sum || cout_o !== model_cout) held_ok = 1'b0;
    end
    check_eq("run_hold", 32'(held_ok), 32'd1);
    check_eq("latency", 32'(k), 32'(W));
    check_eq("done_busy", 32'(busy_o), 32'd0);
    check_eq("sum", 32'(sum_o), 32'(pend_sum));
    check_eq("cout", 32'(cout_o), 32'(pend_cout));
    model_sum  = pend_sum;
    model_cout = pend_cout;
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    check_eq("idle_done", 32'(done_o), 32'd0);
    check_eq("idle_busy", 32'(busy_o), 32'd0);
    check_eq("idle_sum", 32'({cout_o, sum_o}), 32'({model_cout, model_sum}));
  endtask

  initial begin
    bit no_done;
    // Reset with start asserted.
    rst_n = 1'b0; start_i = 1'b1; a_i = 8'hAA; b_i = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_sum", 32'(sum_o), 32'd0);
    check_eq("rst_cout", 32'(cout_o), 32'd0);
    rst_n = 1'b1; start_i = 1'b0;
    idle_check();

    // Directed cases.
    start_op(8'h3C, 8'h05, 1'b0, 1'b0); wait_done(0); idle_check();
    start_op(8'hFF, 8'h00, 1'b1, 1'b0); wait_done(0); idle_check();
    start_op(8'hFF, 8'hFF, 1'b1, 1'b0); wait_done(0); idle_check();

    // Ignored start mid-run, then back-to-back via the done cycle.
    start_op(8'h22, 8'h11, 1'b0, 1'b0); wait_done(3);
    start_op(8'h10, 8'h20, 1'b0, 1'b0); wait_done(0); idle_check();

    // Abort mid-run: reset hits on the 4th RUN edge.
    start_op(8'h7F, 8'h01, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("abort_busy", 32'(busy_o), 32'd0);
    check_eq("abort_out", 32'({cout_o, sum_o}), 32'd0);
    model_sum = '0; model_cout = 1'b0;
    no_done = 1'b1;
    for (int i = 0; i < int'(W) + 2; i++) begin
      @(posedge clk); #1;
      if (done_o !== 1'b0) no_done = 1'b0;
    end
    check_eq("abort_no_done", 32'(no_done), 32'd1);
    start_op(8'h80, 8'h80, 1'b0, 1'b0); wait_done(0); idle_check();

`ifdef SERIAL_ADD_SUB_EN
    start_op(8'h10, 8'h01, 1'b1, 1'b1); wait_done(0); idle_check();
    start_op(8'h01, 8'h02, 1'b0, 1'b1); wait_done(0); idle_check();
`endif

    // Randomized operations, some chained back-to-back, some with ignored starts.
    for (int n = 0; n < 24; n++) begin
      logic sv;
      sv = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sv = 1'($urandom);
`endif
      start_op(W'($urandom), W'($urandom), 1'($urandom), sv);
      wait_done(($urandom_range(1) == 1) ? int'($urandom_range(W - 1, 1)) : 0);
      if ($urandom_range(1) == 1) idle_check();
    end
    idle_check();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
